// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//
// Takes the byte/strobe pair from the memory stage on a store to the UART
// MMIO address, buffers bytes in a small circular FIFO and shifts them out as
// 8N1 frames (start bit, 8 data bits LSB first, stop bit) on one serial line.
// The core never stalls: a write that arrives while the FIFO is full is
// dropped and latched in the sticky overflow flag.
//
// Ports
//   clk         core clock, all state updates on the rising edge
//   rst         asynchronous, active-low reset
//   wr_data     byte from the memory stage
//   wr_en       write strobe, one cycle per byte
//   tx          serial line, idle high, registered
//   tx_busy     high while a frame is being shifted
//   fifo_empty  FIFO holds no bytes
//   fifo_full   FIFO holds FIFO_DEPTH bytes
//   fifo_count  bytes currently buffered
//   overflow    sticky, set when a write is dropped; cleared only by reset
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (line low) for one bit period
// S_DATA  | 8 data bits, LSB first, one bit period each
// S_STOP  | stop bit (line high); pops the next byte for back-to-back frames

module uart_tx_serializer #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_en,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    assign fifo_count = count_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign head       = mem[rd_ptr];

    // Full is judged on the pre-edge count, so a write while full is dropped
    // even when the serializer pops on the same edge.
    assign push = wr_en && !fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              tx_q;
    logic              tx_d;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign tx      = tx_q;
    assign tx_busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is a function of the current state, so the line lags the state
    // register by one cycle: a pop at edge N+1 drives the start bit at N+2.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int CLK_FREQ = 400;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       fifo_empty;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    uart_tx_serializer #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: byte queue plus position inside the current frame.
    // m_pos counts edges since the byte was popped (-1 when idle).
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    logic [7:0] m_popped[$];
    logic [7:0] m_cur = 8'h00;
    int         m_pos = -1;
    bit         m_ovf = 1'b0;
    bit         m_tx  = 1'b1;

    function automatic bit line_at(input int pos, input logic [7:0] b);
        int k;
        if (pos < 0) return 1'b1;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    initial begin
        bit full_pre;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_popped.delete();
                m_pos = -1;
                m_ovf = 1'b0;
                m_tx  = 1'b1;
            end else begin
                full_pre = (m_q.size() == DEPTH);
                m_tx = line_at(m_pos, m_cur);
                if (m_pos < 0 || m_pos == FRAME - 1) begin
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front();
                        m_popped.push_back(m_cur);
                        m_pos = 0;
                    end else begin
                        m_pos = -1;
                    end
                end else begin
                    m_pos++;
                end
                if (wr_en) begin
                    if (full_pre) m_ovf = 1'b1;
                    else m_q.push_back(wr_data);
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("tx", tx, m_tx);
            chk("tx_busy", tx_busy, m_pos >= 0);
            chk("fifo_count", fifo_count, m_q.size());
            chk("fifo_empty", fifo_empty, m_q.size() == 0);
            chk("fifo_full", fifo_full, m_q.size() == DEPTH);
            chk("overflow", overflow, m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Serial decoder: samples the middle of each bit period.
    // ------------------------------------------------------------------
    int         d_cnt = -1;
    logic [7:0] d_byte = 8'h00;
    int         rx_frames = 0;
    logic [7:0] rx_log[$];
    int         busy_cyc = 0;

    always @(negedge clk) begin
        logic [7:0] want;
        int k;
        if (!rst) d_cnt = -1;
        else if (d_cnt < 0) begin
            if (tx === 1'b0) d_cnt = 0;
        end else d_cnt++;
        if (rst && d_cnt >= 0 && (d_cnt % CPB) == CPB / 2) begin
            k = d_cnt / CPB;
            if (k == 0) chk("rx_start_bit", tx, 1'b0);
            else if (k <= 8) d_byte[k-1] = tx;
            else begin
                chk("rx_stop_bit", tx, 1'b1);
                rx_frames++;
                rx_log.push_back(d_byte);
                chk("rx_popped_avail", m_popped.size() > 0, 1'b1);
                if (m_popped.size() > 0) begin
                    want = m_popped.pop_front();
                    chk("rx_byte", d_byte, want);
                end
            end
        end
        if (d_cnt == FRAME - 1) d_cnt = -1;
        if (rst && tx_busy) busy_cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while ((tx_busy || !fifo_empty) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_in_time"}, n < limit, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic write_burst(input logic [7:0] first, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    logic [39:0] wave;
    logic [9:0]  exp_frame;
    int          f0;
    int          n;
    int          sent;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single 0xA5 frame
        f0 = rx_frames;
        busy_cyc = 0;
        exp_frame = {1'b1, 8'hA5, 1'b0};
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk); wr_en = 1'b0;
        chk("t1_count_after_write", fifo_count, 1);
        chk("t1_busy_before_pop", tx_busy, 1'b0);
        @(negedge clk);
        chk("t1_count_after_pop", fifo_count, 0);
        chk("t1_busy_after_pop", tx_busy, 1'b1);
        chk("t1_tx_before_start", tx, 1'b1);
        @(negedge clk);
        wave[0] = tx;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            wave[i] = tx;
        end
        for (int k = 0; k < 10; k++) chk($sformatf("t1_bit%0d", k), wave[4*k +: 4], {4{exp_frame[k]}});
        wait_idle(20, "t1");
        chk("t1_busy_cycles", busy_cyc, 40);
        chk("t1_frames", rx_frames - f0, 1);
        chk("t1_rx", rx_log[rx_log.size()-1], 8'hA5);

        // 2: three back-to-back frames
        f0 = rx_frames;
        busy_cyc = 0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
        @(negedge clk); wr_data = 8'h0F;
        chk("t2_count_first", fifo_count, 1);
        @(negedge clk); wr_data = 8'hFF;
        @(negedge clk); wr_en = 1'b0;
        chk("t2_count_third", fifo_count, 2);
        @(negedge clk);
        chk("t2_count_hold", fifo_count, 2);
        wait_idle(200, "t2");
        chk("t2_busy_cycles", busy_cyc, 120);
        chk("t2_frames", rx_frames - f0, 3);
        chk("t2_rx0", rx_log[rx_log.size()-3], 8'h55);
        chk("t2_rx1", rx_log[rx_log.size()-2], 8'h0F);
        chk("t2_rx2", rx_log[rx_log.size()-1], 8'hFF);

        // 3: overflow with six writes while idle
        do_reset();
        f0 = rx_frames;
        write_burst(8'h10, 6);
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_count", fifo_count, 4);
        wait_idle(300, "t3");
        chk("t3_frames", rx_frames - f0, 5);
        chk("t3_overflow_sticky", overflow, 1'b1);
        for (int k = 0; k < 5; k++) chk($sformatf("t3_rx%0d", k), rx_log[rx_log.size()-5+k], 8'h10 + 8'(k));

        // 4: asynchronous reset mid-DATA
        do_reset();
        f0 = rx_frames;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk); wr_data = 8'h11;
        @(negedge clk); wr_data = 8'h22;
        @(negedge clk); wr_en = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_busy_mid", tx_busy, 1'b1);
        chk("t4_queued", fifo_count, 2);
        #1 rst = 1'b0;
        #1;
        chk("t4_async_tx", tx, 1'b1);
        chk("t4_async_busy", tx_busy, 1'b0);
        chk("t4_async_count", fifo_count, 0);
        chk("t4_async_empty", fifo_empty, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        busy_cyc = 0;
        repeat (60) @(negedge clk);
        chk("t4_no_frames", rx_frames - f0, 0);
        chk("t4_no_busy", busy_cyc, 0);

        // 5: write while full on the same edge as a pop
        do_reset();
        f0 = rx_frames;
        write_burst(8'hA0, 5);
        chk("t5_full", fifo_full, 1'b1);
        chk("t5_overflow_clear", overflow, 1'b0);
        n = 0;
        while (m_pos != FRAME - 1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_pop", n < 80, 1'b1);
        wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk); wr_en = 1'b0;
        chk("t5_count", fifo_count, 3);
        chk("t5_overflow", overflow, 1'b1);
        wait_idle(300, "t5");
        chk("t5_frames", rx_frames - f0, 5);
        chk("t5_last_rx", rx_log[rx_log.size()-1], 8'hA4);

        // 6: pointer wrap with flow-controlled writes
        do_reset();
        f0 = rx_frames;
        sent = 0;
        n = 0;
        while (sent < 2*DEPTH+3 && n < 2000) begin
            @(negedge clk);
            if (!fifo_full) begin
                wr_en   = 1'b1;
                wr_data = 8'h40 + 8'(sent);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            n++;
        end
        @(negedge clk); wr_en = 1'b0;
        chk("t6_all_sent", sent, 2*DEPTH+3);
        wait_idle(700, "t6");
        chk("t6_frames", rx_frames - f0, 2*DEPTH+3);
        chk("t6_overflow", overflow, 1'b0);
        for (int k = 0; k < 2*DEPTH+3; k++)
            chk($sformatf("t6_rx%0d", k), rx_log[rx_log.size()-(2*DEPTH+3)+k], 8'h40 + 8'(k));

        // Random traffic, heavy then light
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 9) < 2);
            wr_data = 8'($urandom);
        end
        @(negedge clk); wr_en = 1'b0;
        wait_idle(800, "rand_heavy");
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 49) == 0);
            wr_data = 8'($urandom);
        end
        @(negedge clk); wr_en = 1'b0;
        wait_idle(800, "rand_light");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Consumes the byte/strobe pair the data memory produces on a store to the UART MMIO address. Buffers bytes in a small FIFO and shifts them out as 8N1 frames on a single serial line. Sits directly downstream of the memory-access stage, at the core/board boundary. The core never stalls: bytes that arrive while the FIFO is full are dropped and flagged.

Parameters:
CLK_FREQ, 50000000, core clock frequency in Hz
BAUD, 115200, serial bit rate
FIFO_DEPTH, 16, byte entries; power of two, ≥2
CLKS_PER_BIT, CLK_FREQ/BAUD (derived localparam, integer division), clocks per serial bit; must be ≥2

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
wr_data  input  8  byte from the memory stage (uart_tx_out)
wr_en  input  1  write strobe, one cycle per byte (uart_tx_ready)
tx  output  1  serial line, idle high
tx_busy  output  1  high while a frame is being shifted (state != IDLE)
fifo_empty  output  1  FIFO holds no bytes
fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
overflow  output  1  sticky; set when a write is dropped

Behaviour:
- Reset (rst=0, asynchronous, any cycle, including mid-frame): tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0.
  - Read/write pointers, baud counter and bit index are cleared; FSM goes to IDLE.
  - A frame in progress is abandoned and the line returns high immediately. There is no glitch requirement on tx beyond returning to 1.
- FIFO: circular buffer. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Flags derive from the registered count.
- Push: wr_en=1 and fifo_full=0 at an edge -> store wr_data at the write pointer, increment the pointer.
- wr_en=1 with fifo_full=1: the byte is dropped and overflow is set. overflow stays set until reset.
  - The full check uses the pre-edge count. A write while full is dropped even if a pop occurs on the same edge.
- Simultaneous push and pop when not full: both happen and fifo_count is unchanged.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1. Each bit period is exactly CLKS_PER_BIT cycles.
  - IDLE: tx=1. If fifo_empty=0, pop the head into an 8-bit shift register, clear the baud counter and go to START.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. At the end of each bit period, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: tx=1 for one bit period. At the end, if fifo_empty=0, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- tx is registered.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1, and tx falls at edge N+2. Frame length is 10*CLKS_PER_BIT cycles.
- tx_busy=1 in START, DATA and STOP.
- A popped byte has left the FIFO: fifo_count reflects it from the pop edge.
- Writes are accepted in every FSM state; transmission never blocks input.

Test Plan:
1. CLK_FREQ=400, BAUD=100 (CLKS_PER_BIT=4). Reset, then write 0xA5 once -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. tx_busy high for 40 cycles. fifo_count returns to 0 one cycle after the write-induced pop.
2. Write 0x55, 0x0F, 0xFF on three consecutive cycles -> three frames with no idle gap between them (total 120 cycles busy). fifo_count sequence 1,2,2 then decrements at each frame start.
3. FIFO_DEPTH=4. Write 6 bytes back-to-back while IDLE -> the first byte is popped, 4 are buffered, and the 6th is dropped. overflow=1 and remains 1 after all frames complete. Exactly 5 frames appear on tx.
4. Assert rst=0 mid-DATA of a 0x3C frame with 2 bytes queued -> tx=1, tx_busy=0, fifo_count=0 and fifo_empty=1 in the same cycle, asynchronously. No further frames are sent after release.
5. Full FIFO with a pop and a write on the same edge -> the write is dropped and overflow=1. fifo_count goes from FIFO_DEPTH to FIFO_DEPTH-1.
6. Pointer wrap: stream 2*FIFO_DEPTH+3 bytes with incrementing values, writing only when not full -> all bytes are received in order by the bench's serial decoder and overflow=0.
